crc_checker: RTL and testbench

Receive-side companion to `crc_generator`. It consumes a byte stream in which each frame is payload bytes followed by one CRC-8 byte. It recomputes the CRC over the payload, compares it with the received CRC byte, and reports pass/fail, the payload length and a running error count. It sits at the receive end of any link fed by `crc_generator`, and both blocks use the same CRC definition.

---
 rtl/crc_checker_if.sv | 9 +
 rtl/crc_checker.sv | 87 ++++++++
 tb/tb_crc_checker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/crc_checker_if.sv
// Byte-stream bundle feeding crc_checker: one byte per valid cycle, last marks the CRC byte.
interface crc_checker_if;
    logic [7:0] data;
    logic       valid;
    logic       last;

    modport master (output data, output valid, output last);
    modport slave  (input  data, input  valid, input  last);
endinterface

// File: rtl/crc_checker.sv
// Receive-side CRC-8 (poly 0x07, init 0x00, MSB-first) frame checker.
// Each frame is payload bytes followed by one CRC byte flagged with last.
module crc_checker #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    crc_checker_if.slave     bus,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [7:0]       crc_calc,
    output logic [LEN_W-1:0] frame_len,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic             state;
    logic [7:0]       crc_r;
    logic [LEN_W-1:0] len_r;
    logic [7:0]       crc_base;
    logic [7:0]       crc_next;
    logic             match;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // A frame started from IDLE always seeds from 0x00, whatever crc_r holds.
    always_comb begin
        crc_base = (state == IDLE) ? 8'h00 : crc_r;
        crc_next = crc8_byte(crc_base, bus.data);
        match    = (bus.data == crc_base);
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            crc_r     <= 8'h00;
            len_r     <= '0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            crc_calc  <= 8'h00;
            frame_len <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            if (bus.valid) begin
                if (bus.last) begin
                    done      <= 1'b1;
                    crc_ok    <= match;
                    crc_err   <= ~match;
                    crc_calc  <= crc_base;
                    frame_len <= (state == IDLE) ? '0 : len_r;
                    if (!match && (err_count != {CNT_W{1'b1}})) begin
                        err_count <= err_count + 1'b1;
                    end
                    state <= IDLE;
                    crc_r <= 8'h00;
                    len_r <= '0;
                end else begin
                    state <= RUN;
                    crc_r <= crc_next;
                    // Length saturates; the CRC keeps running over extra bytes.
                    if (state == IDLE) begin
                        len_r <= {{(LEN_W-1){1'b0}}, 1'b1};
                    end else if (len_r != {LEN_W{1'b1}}) begin
                        len_r <= len_r + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: directed scenarios plus random frames against
// a polynomial-division reference model.
module tb_crc_checker;

    logic        clk;
    logic        reset;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic [7:0]  crc_calc;
    logic [7:0]  frame_len;
    logic [15:0] err_count;
    logic        busy;

    crc_checker_if bus ();

    crc_checker #(.LEN_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .crc_calc  (crc_calc),
        .frame_len (frame_len),
        .err_count (err_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl[$];
    logic       e_done, e_ok, e_err, e_busy;
    logic [7:0] e_calc;
    int         e_len;
    int         e_cnt;

    // CRC as remainder of (message * x^8) mod 0x107, by long division bit by bit.
    function automatic logic [7:0] model_crc();
        logic [8:0] rem;
        rem = 9'h000;
        for (int k = 0; k < pl.size() + 1; k++) begin
            for (int i = 7; i >= 0; i--) begin
                logic [7:0] b;
                b   = (k < pl.size()) ? pl[k] : 8'h00;
                rem = {rem[7:0], b[i]};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        return rem[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},      32'(done),      32'(e_done));
        chk({tag, ".crc_ok"},    32'(crc_ok),    32'(e_ok));
        chk({tag, ".crc_err"},   32'(crc_err),   32'(e_err));
        chk({tag, ".crc_calc"},  32'(crc_calc),  32'(e_calc));
        chk({tag, ".frame_len"}, 32'(frame_len), 32'(e_len));
        chk({tag, ".err_count"}, 32'(err_count), 32'(e_cnt));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    endtask

    task automatic model_reset();
        pl.delete();
        e_done = 0; e_ok = 0; e_err = 0; e_busy = 0;
        e_calc = 8'h00; e_len = 0; e_cnt = 0;
    endtask

    task automatic push(input logic [7:0] d, input logic l, input string tag);
        logic [7:0] c;
        @(negedge clk);
        bus.data = d; bus.valid = 1'b1; bus.last = l;
        @(posedge clk);
        #1;
        if (l) begin
            c      = model_crc();
            e_ok   = (d == c);
            e_err  = !e_ok;
            e_calc = c;
            e_len  = (pl.size() > 255) ? 255 : pl.size();
            if (!e_ok && e_cnt != 16'hFFFF) e_cnt++;
            pl.delete();
            e_done = 1; e_busy = 0;
        end else begin
            pl.push_back(d);
            e_done = 0; e_busy = 1;
        end
        check_all(tag);
        bus.valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        bus.valid = 1'b0;
        bus.data  = 8'($urandom);
        bus.last  = 1'($urandom);
        @(posedge clk);
        #1;
        e_done = 0;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        int n;
        bus.data = 8'h00; bus.valid = 1'b0; bus.last = 1'b0;
        reset = 1'b0;
        model_reset();

        async_reset("reset");
        idle("reset_idle0");
        idle("reset_idle1");

        // Check value of "123456789"
        for (int i = 0; i < 9; i++) push(8'h31 + 8'(i), 1'b0, "chkval_pl");
        push(8'hF4, 1'b1, "chkval_last");
        chk("chkval_calc_const", 32'(crc_calc), 32'h0000_00F4);
        chk("chkval_len_const", 32'(frame_len), 32'd9);
        chk("chkval_ok_const", 32'(crc_ok), 32'd1);
        idle("chkval_done_drop");

        // Pass then fail, back-to-back
        push(8'hAB, 1'b0, "pf1_pl");
        push(8'h58, 1'b1, "pf1_last");
        chk("pf1_ok_const", 32'(crc_ok), 32'd1);
        push(8'hAB, 1'b0, "pf2_pl");
        push(8'h59, 1'b1, "pf2_last");
        chk("pf2_err_const", 32'(crc_err), 32'd1);
        chk("pf2_calc_const", 32'(crc_calc), 32'h58);
        chk("pf2_cnt_const", 32'(err_count), 32'd1);
        idle("pf_idle");

        // Gaps inside the frame; busy must stay high through them
        for (int i = 0; i < 9; i++) begin
            push(8'h31 + 8'(i), 1'b0, "gap_pl");
            if (i == 2) for (int g = 0; g < 3; g++) idle("gap_mid");
        end
        idle("gap_pre_last");
        push(8'hF4, 1'b1, "gap_last");
        chk("gap_calc_const", 32'(crc_calc), 32'h0000_00F4);
        idle("gap_idle");

        // Zero-payload frames
        push(8'h00, 1'b1, "zero_ok");
        chk("zero_len_const", 32'(frame_len), 32'd0);
        push(8'h07, 1'b1, "zero_bad");
        chk("zero_err_const", 32'(crc_err), 32'd1);
        idle("zero_idle");

        // Reset mid-frame
        push(8'h31, 1'b0, "mid_pl0");
        push(8'h32, 1'b0, "mid_pl1");
        async_reset("mid_reset");
        push(8'hAB, 1'b0, "mid_new_pl");
        push(8'h58, 1'b1, "mid_new_last");
        chk("mid_cnt_const", 32'(err_count), 32'd0);
        chk("mid_len_const", 32'(frame_len), 32'd1);

        // Random frames, random gaps, about half corrupted
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                push(8'($urandom), 1'b0, "rnd_pl");
                if ($urandom_range(0, 3) == 0) idle("rnd_gap");
            end
            c = model_crc();
            if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
            push(c, 1'b1, "rnd_last");
            if ($urandom_range(0, 2) == 0) idle("rnd_idle");
        end

        // Long frame: length saturates, CRC keeps going
        for (int i = 0; i < 260; i++) push(8'($urandom), 1'b0, "long_pl");
        push(model_crc(), 1'b1, "long_last");
        chk("long_len_const", 32'(frame_len), 32'd255);
        idle("long_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
